regfile_scoreboard: RTL

Parametrised successor to the integer register file for the RV32IM pipeline. It provides NREAD combinational read ports, one writeback port and a hardwired-zero x0. It adds a per-register pending-write scoreboard that the decode stage uses for hazard stalls. A sequential init sweep replaces the single-cycle parallel reset of the array. The block sits between ID (read, reserve) and WB (write, release).

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/rf_pend_ctr.sv | 45 ++++
 rtl/regfile_scoreboard.sv | 133 +++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the scoreboarded integer register file.
// Optional feature macro: RF_BYPASS_EN (same-cycle writeback forwarding).
package regfile_pkg;

    // Sweep-then-run controller states.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int XLEN_DEF     = 32;
    localparam int DEPTH_DEF    = 32;
    localparam int PEND_MAX_DEF = 3;

    // Width of a pending-write counter that must hold 0..pmax.
    function automatic int pend_width(input int pmax);
        return $clog2(pmax + 1);
    endfunction

    localparam int PW = pend_width(PEND_MAX_DEF);

endpackage

// File: rtl/rf_pend_ctr.sv
// Saturating up/down pending-write counter for one architectural register.
// Increments are refused at PEND_MAX, decrements are dropped at zero, and a
// simultaneous accepted increment and decrement cancel out.
module rf_pend_ctr
    import regfile_pkg::*;
#(
    parameter int PEND_MAX = PEND_MAX_DEF,
    parameter int CW       = PW
) (
    input  logic          CLK,
    input  logic          clr_i,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [CW-1:0] count_o,
    output logic          full_o
);

    logic [CW-1:0] count_q, count_d;
    logic          inc_ok, dec_ok;

    assign full_o  = (count_q == CW'(PEND_MAX));
    assign inc_ok  = inc_i && !full_o;
    assign dec_ok  = dec_i && (count_q != '0);
    assign count_o = count_q;

    // Next count: clear wins, otherwise apply the net of accepted events.
    always_comb begin
        // NOTE: default assigned first so every path drives count_d and no latch is inferred.
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_ok && !dec_ok) begin
            count_d = count_q + CW'(1);
        end else if (dec_ok && !inc_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    // Counter register; clearing comes in through clr_i.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge values.
        count_q <= count_d;
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with NREAD combinational read ports, one writeback
// port, hardwired-zero x0 and a per-register pending-write scoreboard.
// After reset a sequential sweep loads reg[i] = i, then READY rises.
// Optional feature macro: RF_BYPASS_EN forwards WB_DATA to matching reads.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int  XLEN     = XLEN_DEF,
    parameter int  DEPTH    = DEPTH_DEF,
    parameter int  NREAD    = 2,
    parameter int  PEND_MAX = PEND_MAX_DEF,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [NREAD*AW-1:0]   RADDR,
    output logic [NREAD*XLEN-1:0] RDATA,
    output logic [NREAD-1:0]      RBUSY,
    input  logic                  WB_EN,
    input  logic [AW-1:0]         WB_ADDR,
    input  logic [XLEN-1:0]       WB_DATA,
    input  logic                  RSV_EN,
    input  logic [AW-1:0]         RSV_ADDR,
    output logic                  RSV_FULL,
    output logic                  READY
);

    localparam int CW = pend_width(PEND_MAX);

    state_e                    state_q, state_d;
    logic [AW-1:0]             idx_q, idx_d;
    logic [XLEN-1:0]           mem_q [DEPTH];
    logic [DEPTH-1:0][CW-1:0]  cnt_w;
    logic [DEPTH-1:0]          full_w;
    logic                      run_w;
    logic                      ctr_clr_w;

    assign run_w     = (state_q == RUN);
    assign ctr_clr_w = RESET || !run_w;
    assign READY     = run_w;

    // Next-state logic: step the sweep index through every register, then run.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            INIT: begin
                idx_d = idx_q + AW'(1);
                if (idx_q == AW'(DEPTH - 1)) begin
                    state_d = RUN;
                    idx_d   = '0;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    // Controller state register with synchronous reset back into the sweep.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= INIT;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Array write: sweep loads index values, RUN takes writeback (x0 dropped).
    always_ff @(posedge CLK) begin
        // NOTE: the array has no reset term; the init sweep defines its contents instead.
        if (!RESET) begin
            if (state_q == INIT) begin
                mem_q[idx_q] <= XLEN'(idx_q);
            end else if (WB_EN && (WB_ADDR != '0)) begin
                mem_q[WB_ADDR] <= WB_DATA;
            end
        end
    end

    // x0 has no counter: never busy, never full.
    assign cnt_w[0]  = '0;
    assign full_w[0] = 1'b0;

    for (genvar r = 1; r < DEPTH; r++) begin : g_ctr
        rf_pend_ctr #(
            .PEND_MAX (PEND_MAX),
            .CW       (CW)
        ) u_ctr (
            .CLK     (CLK),
            .clr_i   (ctr_clr_w),
            .inc_i   (run_w && RSV_EN && (RSV_ADDR == AW'(r))),
            .dec_i   (run_w && WB_EN && (WB_ADDR == AW'(r))),
            .count_o (cnt_w[r]),
            .full_o  (full_w[r])
        );
    end

    assign RSV_FULL = run_w && full_w[RSV_ADDR];

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [AW-1:0]   addr_w;
        logic [XLEN-1:0] data_w;
        logic            busy_w;

        assign addr_w = RADDR[k*AW +: AW];

        // Read port: blanked during the sweep, x0 reads zero, optional forwarding.
        always_comb begin
            data_w = '0;
            busy_w = 1'b1;
            if (run_w) begin
                if (addr_w == '0) begin
                    busy_w = 1'b0;
                end else begin
                    data_w = mem_q[addr_w];
                    busy_w = (cnt_w[addr_w] != '0);
`ifdef RF_BYPASS_EN
                    if (WB_EN && (WB_ADDR == addr_w)) begin
                        data_w = WB_DATA;
                        busy_w = (cnt_w[addr_w] > CW'(1));
                    end
`endif
                end
            end
        end

        assign RDATA[k*XLEN +: XLEN] = data_w;
        assign RBUSY[k]              = busy_w;
    end

endmodule
